event_buffer_scheduler: RTL and testbench
=========================================

// Module: event_buffer_scheduler
// PURPOSE
//   Captures one record per accepted trigger (timestamp, TOT_SHORT, TOT_LONG) into an internal event RAM.
//   Schedules the single RAM port between the trigger-side writer and the readout side.
//   Sits after TRIGGER_HANDLER on CLK_FAST. Readout is gated by READ_MODE from the control byte.
//   Each record is 4 x 16-bit words: w0=TS[31:16], w1=TS[15:0], w2=TOT_SHORT, w3=TOT_LONG.
// PARAMETERS
//   ADDR_W  8  log2 of event slots; RAM holds 4*2^ADDR_W x 16-bit words (infers BRAM)
// PORTS
//   CLK             in   1         fast clock (CLK_FAST)
//   RESET           in   1         asynchronous, active-high reset
//   TRIGGER_ACTIVE  in   1         trigger level from TRIGGER_HANDLER; rising edge = event
//   TOT_SHORT       in   16        short-window TOT, sampled on accepted edge
//   TOT_LONG        in   16        long-window TOT, sampled on accepted edge
//   READ_MODE       in   1         1 = readout mode: no new captures, reads permitted
//   SOFT_RESET      in   1         synchronous clear of buffer, counters and timestamp
//   RD_REQ          in   1         request next word (single-cycle pulse)
//   RD_VALID        out  1         one-cycle strobe, RD_DATA valid
//   RD_DATA         out  16        word read from buffer
//   EVENT_COUNT     out  ADDR_W+1  complete records stored
//   EMPTY           out  1         EVENT_COUNT==0
//   OVERFLOW        out  1         sticky: an edge arrived while buffer full
//   DROPPED         out  16        edges not stored (busy/full/READ_MODE), saturates 16'hFFFF
//   NTRIGGERS       out  32        all rising edges seen, wraps
//   BUSY            out  1         writer FSM not IDLE
// BEHAVIOUR
//   Reset: all outputs 0, pointers 0, both FSMs IDLE, timestamp 0. SOFT_RESET does the same synchronously.
//     SOFT_RESET overrides every other event in that cycle.
//   Timestamp: free-running 32-bit counter, +1 per CLK, wraps 0xFFFFFFFF->0.
//   Edge detect: edge = TRIGGER_ACTIVE & ~prev, prev registered. NTRIGGERS+1 on every edge.
//   Writer FSM: IDLE -> W0 -> W1 -> W2 -> W3 -> IDLE.
//     Accept in IDLE only if edge & !READ_MODE & !full. On accept, latch TS, TOT_SHORT, TOT_LONG in the edge cycle.
//     W0..W3 write word k at RAM addr {wr_ptr,k[1:0]}, one word per cycle.
//     On W3: wr_ptr+1 (mod 2^ADDR_W), EVENT_COUNT+1.
//     Edge not accepted -> DROPPED+1 (saturating). If full, OVERFLOW<=1 as well.
//     Edge during W0..W3 is dropped. Snapshot is not altered.
//   full = EVENT_COUNT==2^ADDR_W.
//   READ_MODE rising during W0..W3: the record completes. No truncated records ever exist.
//   Reader FSM: IDLE -> FETCH -> OUT -> IDLE.
//     RD_REQ honoured only when in IDLE & READ_MODE & !EMPTY & writer IDLE (writer has priority).
//     A request that is not honoured is dropped, not queued.
//     FETCH presents addr {rd_ptr,rd_word}. OUT drives RD_DATA, RD_VALID=1 for 1 cycle, rd_word+1.
//     Latency: RD_REQ at cycle n -> RD_VALID at n+2. Maximum rate is 1 word per 3 cycles.
//     RD_REQ while FETCH/OUT is ignored.
//     After OUT of w3: rd_word=0, rd_ptr+1 (mod 2^ADDR_W), EVENT_COUNT-1.
//   RD_DATA holds its last value between strobes.
//   READ_MODE falling: the reader finishes any FETCH/OUT in flight, then sets rd_word=0.
//     A partially read record is re-read from w0 next time.
//   Simultaneous EVENT_COUNT +1 and -1: net unchanged.
//   Pointer wrap: wr_ptr/rd_ptr wrap modulo 2^ADDR_W. Full/empty are decided by EVENT_COUNT only.
// TESTING
//   Setup: ADDR_W=2 (4 slots).
//   1) Reset; TOT_SHORT=16'h0012, TOT_LONG=16'h0345; one edge at TS=100; then READ_MODE=1, 4 RD_REQ
//      -> RD_DATA 0000,0064,0012,0345; each RD_VALID 2 cycles after its RD_REQ; EMPTY=1; NTRIGGERS=1.
//   2) Two edges 2 cycles apart -> 1 record stored, DROPPED=1, OVERFLOW=0.
//   3) 6 well-spaced edges -> EVENT_COUNT=4, DROPPED=2, OVERFLOW=1; read all 16 words -> 4 records in order.
//   4) READ_MODE=1 one cycle after an edge -> that record still stored. A further edge in READ_MODE -> DROPPED+1.
//   5) Read w0,w1, drop READ_MODE, raise again, read 4 words -> starts at w0, EVENT_COUNT decrements once.
//   6) Fill 3, SOFT_RESET mid-W2 -> all counters 0, EMPTY=1.
//      Then 8 write/read cycles -> pointer wrap, data intact.
//      Assert RESET async mid-read -> RD_VALID=0 immediately.

Source files
------------

// File: rtl/event_buffer_scheduler.sv
// Event capture buffer: snapshots (timestamp, TOT_SHORT, TOT_LONG) per accepted trigger
// edge into a single-port RAM and arbitrates that port between the writer and readout.
module event_buffer_scheduler #(
    parameter int ADDR_W = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              TRIGGER_ACTIVE,
    input  logic [15:0]       TOT_SHORT,
    input  logic [15:0]       TOT_LONG,
    input  logic              READ_MODE,
    input  logic              SOFT_RESET,
    input  logic              RD_REQ,
    output logic              RD_VALID,
    output logic [15:0]       RD_DATA,
    output logic [ADDR_W:0]   EVENT_COUNT,
    output logic              EMPTY,
    output logic              OVERFLOW,
    output logic [15:0]       DROPPED,
    output logic [31:0]       NTRIGGERS,
    output logic              BUSY
);

    localparam int SLOTS  = 1 << ADDR_W;
    localparam int DEPTH  = 4 * SLOTS;
    localparam int RAM_AW = ADDR_W + 2;

    typedef enum logic [2:0] {WR_IDLE, WR_W0, WR_W1, WR_W2, WR_W3} wr_state_t;
    typedef enum logic [1:0] {RD_IDLE, RD_FETCH, RD_OUT} rd_state_t;

    wr_state_t wr_state_reg, wr_state_next;
    rd_state_t rd_state_reg, rd_state_next;

    logic [31:0]       ts_reg;
    logic              trig_prev_reg;
    logic [63:0]       snap_reg;
    logic [ADDR_W-1:0] wr_ptr_reg;
    logic [ADDR_W-1:0] rd_ptr_reg;
    logic [1:0]        rd_word_reg;
    logic [ADDR_W:0]   count_reg;
    logic              overflow_reg;
    logic [15:0]       dropped_reg;
    logic [31:0]       ntrig_reg;
    logic [15:0]       rd_data_reg;

    logic [15:0]       mem [DEPTH];

    logic              edge_det;
    logic              full;
    logic              empty;
    logic              accept;
    logic              wr_active;
    logic              wr_last;
    logic [1:0]        wr_word;
    logic              rd_grant;
    logic              rd_fetch;
    logic              rd_out;
    logic              rd_last;
    logic              ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [15:0]       ram_wdata;
    logic [15:0]       snap_word [4];

    // Record layout: w0=TS[31:16], w1=TS[15:0], w2=TOT_SHORT, w3=TOT_LONG.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_snap_word
            assign snap_word[gi] = snap_reg[63 - 16*gi -: 16];
        end
    endgenerate

    assign edge_det  = TRIGGER_ACTIVE & ~trig_prev_reg;
    assign full      = (count_reg == (ADDR_W+1)'(SLOTS));
    assign empty     = (count_reg == '0);
    assign accept    = edge_det && (wr_state_reg == WR_IDLE) && !READ_MODE && !full;
    assign wr_active = (wr_state_reg != WR_IDLE);
    assign wr_last   = (wr_state_reg == WR_W3);

    // The writer owns the port whenever it is active; a grant needs an idle writer.
    assign rd_grant  = RD_REQ && READ_MODE && !empty && !wr_active && (rd_state_reg == RD_IDLE);
    assign rd_fetch  = (rd_state_reg == RD_FETCH);
    assign rd_out    = (rd_state_reg == RD_OUT);
    assign rd_last   = rd_out && (rd_word_reg == 2'd3);

    assign ram_we    = wr_active && !SOFT_RESET;
    assign ram_addr  = wr_active ? {wr_ptr_reg, wr_word} : {rd_ptr_reg, rd_word_reg};
    assign ram_wdata = snap_word[wr_word];

    always_comb begin
        wr_word = 2'd0;
        case (wr_state_reg)
            WR_W1:   wr_word = 2'd1;
            WR_W2:   wr_word = 2'd2;
            WR_W3:   wr_word = 2'd3;
            default: wr_word = 2'd0;
        endcase
    end

    always_comb begin
        wr_state_next = wr_state_reg;
        case (wr_state_reg)
            WR_IDLE: if (accept) wr_state_next = WR_W0;
            WR_W0:   wr_state_next = WR_W1;
            WR_W1:   wr_state_next = WR_W2;
            WR_W2:   wr_state_next = WR_W3;
            WR_W3:   wr_state_next = WR_IDLE;
            default: wr_state_next = WR_IDLE;
        endcase
    end

    always_comb begin
        rd_state_next = rd_state_reg;
        case (rd_state_reg)
            RD_IDLE:  if (rd_grant) rd_state_next = RD_FETCH;
            RD_FETCH: rd_state_next = RD_OUT;
            RD_OUT:   rd_state_next = RD_IDLE;
            default:  rd_state_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_state_reg <= WR_IDLE;
            rd_state_reg <= RD_IDLE;
        end else if (SOFT_RESET) begin
            wr_state_reg <= WR_IDLE;
            rd_state_reg <= RD_IDLE;
        end else begin
            wr_state_reg <= wr_state_next;
            rd_state_reg <= rd_state_next;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ts_reg        <= '0;
            trig_prev_reg <= 1'b0;
            snap_reg      <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            rd_word_reg   <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            dropped_reg   <= '0;
            ntrig_reg     <= '0;
        end else if (SOFT_RESET) begin
            ts_reg        <= '0;
            trig_prev_reg <= 1'b0;
            snap_reg      <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            rd_word_reg   <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            dropped_reg   <= '0;
            ntrig_reg     <= '0;
        end else begin
            ts_reg        <= ts_reg + 32'd1;
            trig_prev_reg <= TRIGGER_ACTIVE;

            if (edge_det) begin
                ntrig_reg <= ntrig_reg + 32'd1;
                if (!accept) begin
                    if (dropped_reg != 16'hFFFF) dropped_reg <= dropped_reg + 16'd1;
                    if (full) overflow_reg <= 1'b1;
                end
            end

            if (accept) snap_reg <= {ts_reg, TOT_SHORT, TOT_LONG};
            if (wr_last) wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);

            // Dropping READ_MODE rewinds a partly read record once the reader is idle.
            if (rd_out) begin
                rd_word_reg <= rd_word_reg + 2'd1;
                if (rd_last) rd_ptr_reg <= rd_ptr_reg + ADDR_W'(1);
            end else if ((rd_state_reg == RD_IDLE) && !READ_MODE) begin
                rd_word_reg <= 2'd0;
            end

            case ({wr_last, rd_last})
                2'b10:   count_reg <= count_reg + (ADDR_W+1)'(1);
                2'b01:   count_reg <= count_reg - (ADDR_W+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rd_data_reg <= '0;
        end else if (SOFT_RESET) begin
            rd_data_reg <= '0;
        end else if (rd_fetch) begin
            rd_data_reg <= mem[ram_addr];
        end
    end

    assign RD_VALID    = rd_out;
    assign RD_DATA     = rd_data_reg;
    assign EVENT_COUNT = count_reg;
    assign EMPTY       = empty;
    assign OVERFLOW    = overflow_reg;
    assign DROPPED     = dropped_reg;
    assign NTRIGGERS   = ntrig_reg;
    assign BUSY        = wr_active;

endmodule

// File: tb/tb_event_buffer_scheduler.sv
// Scoreboard bench for event_buffer_scheduler with a 4-slot buffer: reads push expected
// words and arrival cycles; a negedge monitor pops and compares each RD_VALID strobe.
module tb_event_buffer_scheduler;

    localparam int ADDR_W = 2;

    logic              CLK = 1'b0;
    logic              RESET = 1'b1;
    logic              TRIGGER_ACTIVE = 1'b0;
    logic [15:0]       TOT_SHORT = '0;
    logic [15:0]       TOT_LONG = '0;
    logic              READ_MODE = 1'b0;
    logic              SOFT_RESET = 1'b0;
    logic              RD_REQ = 1'b0;
    logic              RD_VALID;
    logic [15:0]       RD_DATA;
    logic [ADDR_W:0]   EVENT_COUNT;
    logic              EMPTY;
    logic              OVERFLOW;
    logic [15:0]       DROPPED;
    logic [31:0]       NTRIGGERS;
    logic              BUSY;

    event_buffer_scheduler #(.ADDR_W(ADDR_W)) dut (
        .CLK(CLK), .RESET(RESET), .TRIGGER_ACTIVE(TRIGGER_ACTIVE),
        .TOT_SHORT(TOT_SHORT), .TOT_LONG(TOT_LONG), .READ_MODE(READ_MODE),
        .SOFT_RESET(SOFT_RESET), .RD_REQ(RD_REQ), .RD_VALID(RD_VALID),
        .RD_DATA(RD_DATA), .EVENT_COUNT(EVENT_COUNT), .EMPTY(EMPTY),
        .OVERFLOW(OVERFLOW), .DROPPED(DROPPED), .NTRIGGERS(NTRIGGERS), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct { logic [31:0] ts; logic [15:0] s; logic [15:0] l; } rec_t;
    typedef struct { logic [15:0] d; int c; } exp_t;

    rec_t        recs[$];
    exp_t        sb[$];
    int          rword = 0;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] tb_ts;

    always @(posedge CLK) cyc <= cyc + 1;

    // Reference timestamp: counts clocks since the last reset/soft reset.
    always @(posedge CLK or posedge RESET) begin
        if (RESET) tb_ts <= '0;
        else if (SOFT_RESET) tb_ts <= '0;
        else tb_ts <= tb_ts + 32'd1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end else begin
            $display("ok   %s = %h", name, act);
        end
    endtask

    function automatic logic [15:0] word_of(input rec_t r, input int k);
        case (k)
            0:       return r.ts[31:16];
            1:       return r.ts[15:0];
            2:       return r.s;
            default: return r.l;
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic store_edge(input logic [15:0] s, input logic [15:0] l, input bit stored);
        TOT_SHORT = s;
        TOT_LONG  = l;
        if (stored) recs.push_back('{tb_ts, s, l});
        TRIGGER_ACTIVE = 1'b1;
        tick(1);
        TRIGGER_ACTIVE = 1'b0;
    endtask

    task automatic rd_req(input bit honour, input int hold);
        if (honour) begin
            sb.push_back('{word_of(recs[0], rword), cyc + 2});
            rword++;
            if (rword == 4) begin
                recs.delete(0);
                rword = 0;
            end
        end
        RD_REQ = 1'b1;
        tick(hold);
        RD_REQ = 1'b0;
        tick(3 - hold);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge CLK);
            if (RD_VALID === 1'b1) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL rd_unexpected: strobe with data %h at cycle %0d, none expected",
                             RD_DATA, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("rd_data", {16'h0, RD_DATA}, {16'h0, e.d});
                    chk("rd_cycle", 32'(cyc), 32'(e.c));
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        tick(3);
        chk("rst_rd_valid", {31'h0, RD_VALID}, 32'h0);
        chk("rst_rd_data", {16'h0, RD_DATA}, 32'h0);
        chk("rst_count", 32'(EVENT_COUNT), 32'h0);
        chk("rst_empty", {31'h0, EMPTY}, 32'h1);
        chk("rst_flags", {OVERFLOW, BUSY, DROPPED, 14'h0}, 32'h0);
        chk("rst_ntrig", NTRIGGERS, 32'h0);

        // Test 1: one edge when the timestamp reads 100.
        @(negedge CLK);
        RESET = 1'b0;
        repeat (100) @(posedge CLK);
        #1;
        TOT_SHORT = 16'h0012;
        TOT_LONG  = 16'h0345;
        recs.push_back('{32'd100, 16'h0012, 16'h0345});
        TRIGGER_ACTIVE = 1'b1;
        tick(1);
        TRIGGER_ACTIVE = 1'b0;
        chk("t1_busy", {31'h0, BUSY}, 32'h1);
        tick(6);
        chk("t1_count", 32'(EVENT_COUNT), 32'd1);
        READ_MODE = 1'b1;
        tick(1);
        for (int i = 0; i < 4; i++) rd_req(1, 1);
        tick(1);
        chk("t1_empty", {31'h0, EMPTY}, 32'h1);
        chk("t1_ntrig", NTRIGGERS, 32'd1);

        // Test 2: second edge two cycles later lands in W1 and is dropped.
        READ_MODE = 1'b0;
        tick(1);
        store_edge(16'h1111, 16'h2222, 1);
        tick(1);
        store_edge(16'h9999, 16'h9999, 0);
        tick(6);
        chk("t2_count", 32'(EVENT_COUNT), 32'd1);
        chk("t2_dropped", {16'h0, DROPPED}, 32'd1);
        chk("t2_overflow", {31'h0, OVERFLOW}, 32'h0);
        chk("t2_ntrig", NTRIGGERS, 32'd3);
        READ_MODE = 1'b1;
        tick(1);
        for (int i = 0; i < 4; i++) rd_req(1, 1);
        READ_MODE = 1'b0;
        tick(1);

        // Test 3: six spaced edges into four slots.
        for (int i = 0; i < 6; i++) begin
            store_edge(16'(16'h0100 + i), 16'(16'h0A00 + i), i < 4);
            tick(6);
        end
        chk("t3_count", 32'(EVENT_COUNT), 32'd4);
        chk("t3_dropped", {16'h0, DROPPED}, 32'd3);
        chk("t3_overflow", {31'h0, OVERFLOW}, 32'h1);
        READ_MODE = 1'b1;
        tick(1);
        for (int i = 0; i < 16; i++) rd_req(1, 1);
        chk("t3_count_after", 32'(EVENT_COUNT), 32'd0);
        chk("t3_ntrig", NTRIGGERS, 32'd9);

        // Test 4: READ_MODE rises during the write; record must complete.
        READ_MODE = 1'b0;
        tick(1);
        store_edge(16'h0AAA, 16'h0BBB, 1);
        READ_MODE = 1'b1;
        rd_req(0, 1);
        tick(2);
        chk("t4_count", 32'(EVENT_COUNT), 32'd1);
        store_edge(16'hDEAD, 16'hBEEF, 0);
        tick(2);
        chk("t4_dropped", {16'h0, DROPPED}, 32'd4);
        chk("t4_ntrig", NTRIGGERS, 32'd11);
        for (int i = 0; i < 4; i++) rd_req(1, 1);
        chk("t4_empty", {31'h0, EMPTY}, 32'h1);

        // Test 5: partial read, leave and re-enter READ_MODE, re-read from w0.
        READ_MODE = 1'b0;
        tick(1);
        store_edge(16'h5555, 16'h6666, 1);
        tick(6);
        rd_req(0, 1);
        READ_MODE = 1'b1;
        tick(1);
        rd_req(1, 2);
        rd_req(1, 1);
        chk("t5_count_partial", 32'(EVENT_COUNT), 32'd1);
        READ_MODE = 1'b0;
        rword = 0;
        tick(2);
        READ_MODE = 1'b1;
        tick(1);
        for (int i = 0; i < 4; i++) rd_req(1, 1);
        chk("t5_count", 32'(EVENT_COUNT), 32'd0);

        // Test 6: soft reset in the middle of W2 of the third record.
        READ_MODE = 1'b0;
        tick(1);
        store_edge(16'h0C01, 16'h0D01, 0);
        tick(6);
        store_edge(16'h0C02, 16'h0D02, 0);
        tick(6);
        store_edge(16'h0C03, 16'h0D03, 0);
        tick(2);
        SOFT_RESET = 1'b1;
        tick(1);
        SOFT_RESET = 1'b0;
        recs.delete();
        rword = 0;
        chk("t6_count", 32'(EVENT_COUNT), 32'd0);
        chk("t6_empty", {31'h0, EMPTY}, 32'h1);
        chk("t6_dropped", {16'h0, DROPPED}, 32'd0);
        chk("t6_overflow", {31'h0, OVERFLOW}, 32'h0);
        chk("t6_ntrig", NTRIGGERS, 32'd0);
        chk("t6_busy", {31'h0, BUSY}, 32'h0);
        chk("t6_rd_data", {16'h0, RD_DATA}, 32'h0);
        tick(6);
        chk("t6_count_settled", 32'(EVENT_COUNT), 32'd0);

        for (int i = 0; i < 8; i++) begin
            store_edge(16'(16'h3000 + i), 16'(16'h4000 + i), 1);
            tick(6);
            READ_MODE = 1'b1;
            tick(1);
            for (int k = 0; k < 4; k++) rd_req(1, 1);
            READ_MODE = 1'b0;
            tick(1);
        end
        chk("t6_wrap_count", 32'(EVENT_COUNT), 32'd0);
        chk("t6_wrap_ntrig", NTRIGGERS, 32'd8);

        // Async reset while RD_VALID is high.
        store_edge(16'h7777, 16'h8888, 0);
        tick(6);
        READ_MODE = 1'b1;
        tick(1);
        RD_REQ = 1'b1;
        tick(1);
        RD_REQ = 1'b0;
        @(posedge CLK);
        #2;
        chk("ar_valid_before", {31'h0, RD_VALID}, 32'h1);
        RESET = 1'b1;
        #1;
        chk("ar_valid_after", {31'h0, RD_VALID}, 32'h0);
        chk("ar_count", 32'(EVENT_COUNT), 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        READ_MODE = 1'b0;
        tick(3);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
